// File: rtl/draw_sprite.sv
// draw_sprite: overlays a ROM-backed SPR_W x SPR_H bitmap on the VGA stream
// at a per-frame latched (x,y), delaying timing by three clocks.
//
// Ports:
//   clk, rst_n             pixel clock, synchronous active-low reset
//   hcount_in..vblnk_in    timing from the generator
//   rgb_in                 background colour (4:4:4)
//   xpos, ypos, en         requested sprite position / enable
//   rom_addr, rom_data     synchronous sprite ROM (data one clk after addr)
//   hcount_out..vblnk_out  timing delayed by three clocks
//   rgb_out                composed colour
module draw_sprite #(
    parameter int          SPR_W  = 128,
    parameter int          SPR_H  = 256,
    parameter int          ADDR_W = 15,
    parameter logic [10:0] X0     = 11'd0,
    parameter logic [10:0] Y0     = 11'd0,
    parameter logic [11:0] TRANSP = 12'hF0F
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [10:0]       hcount_in,
    input  logic              hsync_in,
    input  logic              hblnk_in,
    input  logic [10:0]       vcount_in,
    input  logic              vsync_in,
    input  logic              vblnk_in,
    input  logic [11:0]       rgb_in,
    input  logic [10:0]       xpos,
    input  logic [10:0]       ypos,
    input  logic              en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [11:0]       rom_data,
    output logic [10:0]       hcount_out,
    output logic              hsync_out,
    output logic              hblnk_out,
    output logic [10:0]       vcount_out,
    output logic              vsync_out,
    output logic              vblnk_out,
    output logic [11:0]       rgb_out
);

    localparam logic [10:0] LATCH_V = 11'd768;
    localparam logic [10:0] LATCH_H = 11'd0;

    typedef struct packed {
        logic [10:0] hcount;
        logic        hsync;
        logic        hblnk;
        logic [10:0] vcount;
        logic        vsync;
        logic        vblnk;
        logic [11:0] rgb;
        logic        in_spr;
    } pix_t;

    localparam pix_t PIX_ZERO = '0;

    logic [10:0] x_l;
    logic [10:0] y_l;
    logic        en_l;

    pix_t s0;
    pix_t s1;
    pix_t s2;

    logic              frame_start;
    logic [11:0]       h12;
    logic [11:0]       v12;
    logic [11:0]       x_beg;
    logic [11:0]       y_beg;
    logic [11:0]       x_end;
    logic [11:0]       y_end;
    logic              in_spr;
    logic [10:0]       row_off;
    logic [10:0]       col_off;
    logic [ADDR_W-1:0] addr_next;
    logic              blank2;
    logic [11:0]       rgb_next;

    // Position is only taken at vblank start so a frame never tears.
    assign frame_start = (vcount_in == LATCH_V) && (hcount_in == LATCH_H);

    // 12-bit compares: a sprite hanging past 2047 must not wrap to the left.
    assign h12   = {1'b0, hcount_in};
    assign v12   = {1'b0, vcount_in};
    assign x_beg = {1'b0, x_l};
    assign y_beg = {1'b0, y_l};
    assign x_end = x_beg + 12'(SPR_W);
    assign y_end = y_beg + 12'(SPR_H);

    assign in_spr = en_l
                  && (h12 >= x_beg) && (h12 < x_end)
                  && (v12 >= y_beg) && (v12 < y_end);

    assign row_off   = vcount_in - y_l;
    assign col_off   = hcount_in - x_l;
    assign addr_next = ADDR_W'(32'(row_off) * SPR_W + 32'(col_off));

    always_comb begin
        s0        = PIX_ZERO;
        s0.hcount = hcount_in;
        s0.hsync  = hsync_in;
        s0.hblnk  = hblnk_in;
        s0.vcount = vcount_in;
        s0.vsync  = vsync_in;
        s0.vblnk  = vblnk_in;
        s0.rgb    = rgb_in;
        s0.in_spr = in_spr;
    end

    // rom_data lines up with s2; blanking always wins.
    assign blank2 = s2.hblnk | s2.vblnk;

    always_comb begin
        rgb_next = s2.rgb;
        if (blank2) begin
            rgb_next = 12'h000;
        end else if (s2.in_spr && (rom_data != TRANSP)) begin
            rgb_next = rom_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_l  <= X0;
            y_l  <= Y0;
            en_l <= 1'b0;
        end else if (frame_start) begin
            x_l  <= xpos;
            y_l  <= ypos;
            en_l <= en;
        end
    end

    // Stage 1: register pixel, hit flag and ROM address.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1       <= PIX_ZERO;
            rom_addr <= '0;
        end else begin
            s1 <= s0;
            if (in_spr) begin
                rom_addr <= addr_next;
            end
        end
    end

    // Stage 2: wait for the ROM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2 <= PIX_ZERO;
        end else begin
            s2 <= s1;
        end
    end

    // Stage 3: compose and drive outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hcount_out <= '0;
            hsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vcount_out <= '0;
            vsync_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            hcount_out <= s2.hcount;
            hsync_out  <= s2.hsync;
            hblnk_out  <= s2.hblnk;
            vcount_out <= s2.vcount;
            vsync_out  <= s2.vsync;
            vblnk_out  <= s2.vblnk;
            rgb_out    <= rgb_next;
        end
    end

endmodule

// File: tb/tb_draw_sprite.sv
// tb_draw_sprite: directed checks of draw_sprite alignment, drawing,
// transparency, frame latching, clipping and reset.
module tb_draw_sprite;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] hcount_in = '0;
    logic        hsync_in = 1'b0;
    logic        hblnk_in = 1'b0;
    logic [10:0] vcount_in = '0;
    logic        vsync_in = 1'b0;
    logic        vblnk_in = 1'b0;
    logic [11:0] rgb_in = '0;
    logic [10:0] xpos = '0;
    logic [10:0] ypos = '0;
    logic        en = 1'b0;
    logic [14:0] rom_addr;
    logic [11:0] rom_data = '0;
    logic [10:0] hcount_out;
    logic        hsync_out;
    logic        hblnk_out;
    logic [10:0] vcount_out;
    logic        vsync_out;
    logic        vblnk_out;
    logic [11:0] rgb_out;

    int pass_cnt = 0;
    int total_cnt = 0;
    int rom_mode = 0;
    logic [14:0] a1;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        case (rom_mode)
            1:       rom_data <= 12'hF0F;
            2:       rom_data <= 12'hABC;
            default: rom_data <= rom_addr[11:0];
        endcase
    end

    draw_sprite dut (
        .clk(clk), .rst_n(rst_n),
        .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
        .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos), .en(en),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .hcount_out(hcount_out), .hsync_out(hsync_out), .hblnk_out(hblnk_out),
        .vcount_out(vcount_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out)
    );

    task automatic set_px(input int h, input int v, input logic [11:0] c);
        @(negedge clk);
        hcount_in = 11'(h);
        vcount_in = 11'(v);
        hblnk_in  = (h >= 1024);
        vblnk_in  = (v >= 768);
        hsync_in  = (h >= 1048 && h < 1184);
        vsync_in  = (v >= 771 && v < 777);
        rgb_in    = c;
    endtask

    // Hold a pixel for three edges; a1 = rom_addr after the first.
    task automatic run_px(input int h, input int v, input logic [11:0] c);
        set_px(h, v, c);
        @(posedge clk); #1;
        a1 = rom_addr;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic latch_pos(input int x, input int y, input logic e);
        xpos = 11'(x);
        ypos = 11'(y);
        en   = e;
        set_px(0, 768, 12'h000);
        @(posedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_px($urandom_range(0, 1343), $urandom_range(0, 805),
                   12'($urandom));
            xpos = 11'($urandom);
            ypos = 11'($urandom);
            en   = 1'($urandom);
        end
        @(posedge clk); #1;
        total_cnt++;
        if (rgb_out !== 12'h000) $display("FAIL reset_rgb got %h want 000", rgb_out);
        else pass_cnt++;
        total_cnt++;
        if ({hcount_out, vcount_out} !== 22'd0)
            $display("FAIL reset_count got %0d,%0d want 0,0", hcount_out, vcount_out);
        else pass_cnt++;
        total_cnt++;
        if ({hsync_out, hblnk_out, vsync_out, vblnk_out} !== 4'b0)
            $display("FAIL reset_sync got %b%b%b%b want 0000",
                     hsync_out, hblnk_out, vsync_out, vblnk_out);
        else pass_cnt++;
        total_cnt++;
        if (rom_addr !== 15'd0) $display("FAIL reset_addr got %0d want 0", rom_addr);
        else pass_cnt++;
        en = 1'b0;
        set_px(0, 0, 12'h000);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_alignment;
        set_px(10, 20, 12'h123);
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if (hcount_out !== 11'd0) $display("FAIL align_early got %0d want 0", hcount_out);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (rgb_out !== 12'h123) $display("FAIL align_rgb got %h want 123", rgb_out);
        else pass_cnt++;
        total_cnt++;
        if (hcount_out !== 11'd10 || vcount_out !== 11'd20)
            $display("FAIL align_count got %0d,%0d want 10,20", hcount_out, vcount_out);
        else pass_cnt++;
        run_px(1100, 20, 12'h456);
        total_cnt++;
        if ({hsync_out, hblnk_out, vblnk_out, rgb_out} !== {3'b110, 12'h000})
            $display("FAIL align_hblank got %b%b%b %h want 110 000",
                     hsync_out, hblnk_out, vblnk_out, rgb_out);
        else pass_cnt++;
    endtask

    task automatic test_draw;
        latch_pos(100, 50, 1'b1);
        run_px(100, 50, 12'h555);
        total_cnt++;
        if (a1 !== 15'd0 || rgb_out !== 12'h000)
            $display("FAIL draw_origin got %0d %h want 0 000", a1, rgb_out);
        else pass_cnt++;
        run_px(227, 305, 12'h555);
        total_cnt++;
        if (a1 !== 15'd32767 || rgb_out !== 12'hFFF)
            $display("FAIL draw_corner got %0d %h want 32767 fff", a1, rgb_out);
        else pass_cnt++;
        run_px(228, 50, 12'h555);
        total_cnt++;
        if (a1 !== 15'd32767 || rgb_out !== 12'h555)
            $display("FAIL draw_right got %0d %h want 32767 555", a1, rgb_out);
        else pass_cnt++;
        run_px(150, 60, 12'h555);
        total_cnt++;
        if (a1 !== 15'd1330 || rgb_out !== 12'h532)
            $display("FAIL draw_mid got %0d %h want 1330 532", a1, rgb_out);
        else pass_cnt++;
    endtask

    task automatic test_transparency;
        rom_mode = 1;
        run_px(120, 60, 12'h456);
        total_cnt++;
        if (rgb_out !== 12'h456) $display("FAIL transp_key got %h want 456", rgb_out);
        else pass_cnt++;
        rom_mode = 2;
        run_px(120, 60, 12'h456);
        total_cnt++;
        if (rgb_out !== 12'hABC) $display("FAIL transp_opaque got %h want abc", rgb_out);
        else pass_cnt++;
        rom_mode = 0;
    endtask

    task automatic test_latch_timing;
        xpos = 11'd300;
        run_px(150, 200, 12'h111);
        total_cnt++;
        if (rgb_out !== 12'hB32) $display("FAIL latch_old_in got %h want b32", rgb_out);
        else pass_cnt++;
        run_px(350, 200, 12'h111);
        total_cnt++;
        if (rgb_out !== 12'h111) $display("FAIL latch_old_out got %h want 111", rgb_out);
        else pass_cnt++;
        latch_pos(300, 50, 1'b1);
        run_px(350, 200, 12'h111);
        total_cnt++;
        if (a1 !== 15'd19250 || rgb_out !== 12'hB32)
            $display("FAIL latch_new_in got %0d %h want 19250 b32", a1, rgb_out);
        else pass_cnt++;
        run_px(150, 200, 12'h111);
        total_cnt++;
        if (rgb_out !== 12'h111) $display("FAIL latch_new_out got %h want 111", rgb_out);
        else pass_cnt++;
    endtask

    task automatic test_clip;
        latch_pos(1000, 50, 1'b1);
        run_px(1010, 60, 12'h222);
        total_cnt++;
        if (rgb_out !== 12'h50A) $display("FAIL clip_in got %h want 50a", rgb_out);
        else pass_cnt++;
        run_px(1023, 60, 12'h222);
        total_cnt++;
        if (rgb_out !== 12'h517) $display("FAIL clip_edge got %h want 517", rgb_out);
        else pass_cnt++;
        run_px(1030, 60, 12'h222);
        total_cnt++;
        if (rgb_out !== 12'h000 || hblnk_out !== 1'b1)
            $display("FAIL clip_blank got %h %b want 000 1", rgb_out, hblnk_out);
        else pass_cnt++;
        latch_pos(1500, 50, 1'b1);
        run_px(1500, 60, 12'h222);
        total_cnt++;
        if (rgb_out !== 12'h000) $display("FAIL clip_off got %h want 000", rgb_out);
        else pass_cnt++;
        run_px(500, 60, 12'h222);
        total_cnt++;
        if (rgb_out !== 12'h222) $display("FAIL clip_pass got %h want 222", rgb_out);
        else pass_cnt++;
        latch_pos(100, 700, 1'b1);
        run_px(150, 767, 12'h222);
        total_cnt++;
        if (rgb_out !== 12'h1B2) $display("FAIL clip_ylast got %h want 1b2", rgb_out);
        else pass_cnt++;
        run_px(150, 770, 12'h222);
        total_cnt++;
        if (rgb_out !== 12'h000 || vblnk_out !== 1'b1)
            $display("FAIL clip_vblank got %h %b want 000 1", rgb_out, vblnk_out);
        else pass_cnt++;
    endtask

    task automatic test_enable_off;
        latch_pos(100, 50, 1'b0);
        run_px(150, 60, 12'h333);
        total_cnt++;
        if (rgb_out !== 12'h333) $display("FAIL en_off got %h want 333", rgb_out);
        else pass_cnt++;
    endtask

    task automatic test_reset_midframe;
        latch_pos(100, 50, 1'b1);
        run_px(150, 60, 12'h777);
        total_cnt++;
        if (rgb_out !== 12'h532) $display("FAIL mid_pre got %h want 532", rgb_out);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        total_cnt++;
        if (rgb_out !== 12'h000 || hcount_out !== 11'd0 || rom_addr !== 15'd0)
            $display("FAIL mid_reset got %h %0d %0d want 000 0 0",
                     rgb_out, hcount_out, rom_addr);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        run_px(150, 60, 12'h777);
        total_cnt++;
        if (rgb_out !== 12'h777) $display("FAIL mid_after got %h want 777", rgb_out);
        else pass_cnt++;
    endtask

    initial begin
        test_reset;
        test_alignment;
        test_draw;
        test_transparency;
        test_latch_timing;
        test_clip;
        test_enable_off;
        test_reset_midframe;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
